// File: rtl/ysyx_23060136_pkg.sv
// Shared definitions for the ysyx_23060136 execute unit.
// Divider FSM states and quotient-bit counts per operand width.
package ysyx_23060136_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  // Quotient bits resolved for a full-width and a word operation.
  localparam int DIV_LAT_DW = 64;
  localparam int DIV_LAT_W  = 32;

endpackage

// File: rtl/ysyx_23060136_exu_div_step.sv
// One restoring division step: shift in a dividend bit, trial subtract.
// Ports: rem_i/bit_i/dvs_i in, rem_o next partial remainder, q_o quotient bit.
module ysyx_23060136_exu_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] diff;

  // rem_i < dvs_i always holds, so the shifted trial fits W+1 bits
  // and a clear borrow bit means the subtraction succeeded.
  always_comb begin
    diff  = {rem_i, bit_i} - {1'b0, dvs_i};
    q_o   = ~diff[W];
    rem_o = q_o ? diff[W-1:0] : {rem_i[W-2:0], bit_i};
  end

endmodule

// File: rtl/ysyx_23060136_exu_div_param.sv
// Iterative restoring divider, BPC quotient bits per cycle, RV div/rem semantics.
// Ports: clk/rst/flush; in_valid/in_ready + operands; out_valid/out_ready + results.
module ysyx_23060136_exu_div_param
  import ysyx_23060136_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = 7;
  localparam int NDW = (XLEN == 32) ? DIV_LAT_W : DIV_LAT_DW;
  localparam logic [CW-1:0] N_D = CW'(NDW / BPC);
  localparam logic [CW-1:0] N_W = CW'(DIV_LAT_W / BPC);
  localparam logic [XLEN-1:0] LO32 = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_W = XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic word_q, word_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rmd_q, rmd_d;

  logic [BPC:0][XLEN-1:0] rem_c;
  logic [BPC:0][XLEN-1:0] dq_c;
  logic [BPC-1:0] qb;

  function automatic logic [XLEN-1:0] sx(
    input logic w, input logic [XLEN-1:0] x);
    if (!w) return x;
    return x[31] ? (x | ~LO32) : (x & LO32);
  endfunction

  // dq holds the left-aligned dividend magnitude; quotient bits
  // shift in from the bottom as dividend bits leave the top.
  assign rem_c[0] = rem_q;
  assign dq_c[0]  = dq_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    ysyx_23060136_exu_div_step #(.W(XLEN)) u_step (
      .rem_i (rem_c[i]),
      .bit_i (dq_c[i][XLEN-1]),
      .dvs_i (dvs_q),
      .rem_o (rem_c[i+1]),
      .q_o   (qb[i])
    );
    assign dq_c[i+1] = {dq_c[i][XLEN-2:0], qb[i]};
  end

  logic [XLEN-1:0] mask, a_x, b_x, a_mag, b_mag;
  logic [XLEN-1:0] wmask, q_raw, r_raw;
  logic a_neg, b_neg, b_zero, ovf;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvs_d   = dvs_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    mask   = is_word ? LO32 : '1;
    a_x    = sx(is_word, dividend);
    b_x    = sx(is_word, divisor);
    a_neg  = is_signed & (is_word ? dividend[31] : dividend[XLEN-1]);
    b_neg  = is_signed & (is_word ? divisor[31] : divisor[XLEN-1]);
    a_mag  = (a_neg ? -a_x : a_x) & mask;
    b_mag  = (b_neg ? -b_x : b_x) & mask;
    b_zero = (divisor & mask) == '0;
    ovf    = is_signed
           && ((dividend & mask) == (is_word ? MIN_W : MIN_D))
           && ((divisor & mask) == mask);

    wmask = word_q ? LO32 : '1;
    q_raw = dq_c[BPC] & wmask;
    r_raw = rem_c[BPC] & wmask;
    q_raw = (qneg_q ? -q_raw : q_raw) & wmask;
    r_raw = (rneg_q ? -r_raw : r_raw) & wmask;

    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          word_d = is_word;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dvs_d  = b_mag;
          dq_d   = is_word ? (a_mag << (XLEN - 32)) : a_mag;
          rem_d  = '0;
          if (b_zero) begin
            quo_d   = '1;
            rmd_d   = a_x;
            state_d = DIV_DONE;
          end else if (ovf) begin
            quo_d   = a_x;
            rmd_d   = '0;
            state_d = DIV_DONE;
          end else begin
            cnt_d   = is_word ? N_W : N_D;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        dq_d  = dq_c[BPC];
        rem_d = rem_c[BPC];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = sx(word_q, q_raw);
          rmd_d   = sx(word_q, r_raw);
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (out_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (flush) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      word_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dvs_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dvs_q   <= dvs_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = (state_q == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div_param.sv
// Bench for the iterative divider: BPC=1 and BPC=2 instances vs a model.
// Ports: drives both DUTs; one summary line at the end.
module tb_ysyx_23060136_exu_div_param;

  logic clk = 1'b0;
  logic rst, flush, out_ready;
  logic iv1, iv2, ir1, ir2, ov1, ov2;
  logic [63:0] dividend, divisor, q1, r1, q2, r2;
  logic is_signed, is_word;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060136_exu_div_param #(.XLEN(64), .BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv1), .in_ready(ir1),
    .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .is_word(is_word),
    .out_valid(ov1), .out_ready(out_ready),
    .quotient(q1), .remainder(r1)
  );

  ysyx_23060136_exu_div_param #(.XLEN(64), .BPC(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv2), .in_ready(ir2),
    .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .is_word(is_word),
    .out_valid(ov2), .out_ready(out_ready),
    .quotient(q2), .remainder(r2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V div/rem semantics, written with plain signed arithmetic.
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit w,
                         output logic [63:0] q, output logic [63:0] r,
                         output bit spec);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    spec = 1'b0;
    if (w) begin
      if (b32 == 0) begin
        q32 = '1; r32 = a32; spec = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = 0; spec = 1'b1;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) begin
        q = '1; r = a; spec = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 0; spec = 1'b1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  task automatic do_op(input int sel, input logic [63:0] a,
                       input logic [63:0] b, input bit s, input bit w,
                       input int hold);
    logic [63:0] eq, er, gq, gr;
    bit spec;
    int lat, elat, n;
    ref_div(a, b, s, w, eq, er, spec);
    elat = spec ? 1 : ((w ? 32 : 64) / (sel ? 2 : 1)) + 1;
    n = 0;
    while (!(sel ? ir2 : ir1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; is_word = w;
    if (sel) iv2 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
    lat = 1;
    while (!(sel ? ov2 : ov1) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("lat s%0d", sel), 64'(lat), 64'(elat));
    gq = sel ? q2 : q1;
    gr = sel ? r2 : r1;
    chk($sformatf("quo %h/%h s=%0d w=%0d", a, b, s, w), gq, eq);
    chk($sformatf("rem %h/%h s=%0d w=%0d", a, b, s, w), gr, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold quo", sel ? q2 : q1, eq);
      chk("hold rem", sel ? r2 : r1, er);
      chk("hold ov", 64'(sel ? ov2 : ov1), 64'd1);
      chk("hold ir", 64'(sel ? ir2 : ir1), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("release ir", 64'(sel ? ir2 : ir1), 64'd1);
    chk("release ov", 64'(sel ? ov2 : ov1), 64'd0);
  endtask

  task automatic gen(output logic [63:0] a, output logic [63:0] b,
                     output bit s, output bit w);
    int k;
    k = $urandom_range(0, 5);
    s = 1'($urandom_range(0, 1));
    w = 1'($urandom_range(0, 1));
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case (k)
      1: begin
        b = 64'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      2: b = w ? {$urandom, 32'h0} : 64'h0;
      3: begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
      end
      4: begin
        a = 64'($urandom_range(0, 5000));
        b = 64'($urandom_range(1, 70));
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [63:0] a, b;
    bit s, w;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    iv1 = 1'b0; iv2 = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0; is_word = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ov1", 64'(ov1), 64'd0);
    chk("rst q1", q1, 64'd0);
    chk("rst r1", r1, 64'd0);
    chk("rst ov2", 64'(ov2), 64'd0);
    chk("rst q2", q2, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst ir1", 64'(ir1), 64'd1);
    chk("rst ir2", 64'(ir2), 64'd1);

    do_op(0, 64'd100, 64'd7, 1'b0, 1'b0, 0);
    do_op(0, -64'sd7, 64'd2, 1'b1, 1'b0, 0);
    do_op(0, 64'h8000_0000, '1, 1'b1, 1'b1, 0);
    do_op(0, 64'd5, 64'd0, 1'b0, 1'b0, 0);
    do_op(0, 64'hFFFF_FFF0, 64'd0, 1'b0, 1'b1, 0);
    do_op(0, 64'd1000, 64'd33, 1'b0, 1'b1, 10);
    do_op(1, '1, 64'h10, 1'b0, 1'b0, 0);

    // flush on the 20th CALC cycle, then a fresh operation
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7;
    is_signed = 1'b0; is_word = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1; iv1 = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush ov", 64'(ov1), 64'd0);
    chk("flush ir", 64'(ir1), 64'd1);
    do_op(0, 64'd9, 64'd3, 1'b0, 1'b0, 0);

    // reset mid-CALC discards the operation
    @(negedge clk);
    dividend = 64'd77; divisor = 64'd5; iv1 = 1'b1;
    @(posedge clk); #1; iv1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst ov", 64'(ov1), 64'd0);
    chk("mrst q", q1, 64'd0);
    chk("mrst r", r1, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst ir", 64'(ir1), 64'd1);
    chk("mrst ov2", 64'(ov1), 64'd0);

    for (int i = 0; i < 60; i++) begin
      gen(a, b, s, w);
      do_op(0, a, b, s, w, 0);
    end
    for (int i = 0; i < 30; i++) begin
      gen(a, b, s, w);
      do_op(1, a, b, s, w, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
